mem_stage: RTL and testbench

- DLX pipeline memory-access stage. Sits between the EX/MEM register and the MEM/WB register, and feeds its 107-bit bundle directly into the MEM/WB register's input.
- Performs loads and stores of byte, halfword and word size against a data memory with a req/ack handshake. Stalls the front of the pipe while an access is outstanding.
- Formats load data (lane select, sign/zero extension) so that writeback only muxes.
- All buses use big-endian bit numbering: bit 0 is the MSB, and byte lane 0 is bits [0:7].

---
 rtl/mem_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- DLX pipeline memory-access stage.
//
// Sits between the EX/MEM register and the MEM/WB register. Non-memory
// instructions pass straight through combinationally. Loads and stores are
// issued to the data memory over a registered req/ack handshake. The front of
// the pipe is stalled while an access is outstanding. Load data is formatted
// here so writeback only has to mux.
//
// All buses use big-endian bit numbering: bit 0 is the MSB, and byte lane 0
// is bits [0:7].
//
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   : adds output misalign_trap. A misaligned half or word access is
//               refused in its accept cycle and flagged for one cycle.
//   undefined : no trap port. The offset is truncated to alignment.
//
// Parameters
//   WIDTH    width of the MEM/WB bundle (107)
//   TIMEOUT  WAIT cycles allowed before an access is abandoned (1..255)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid            EX/MEM slot holds a real instruction
//   next_pc, dest_reg   PC+4 and destination register of the instruction
//   alu_result          ALU result / effective address
//   store_data          store source (low-order bits used for byte/half)
//   mem_read/mem_write  access type (both set = store)
//   pc_to_reg, reg_write, mem_to_reg, load_sign, dsize
//                       writeback controls and access size
//   dmem_req/we/addr/wdata/be   registered data-memory request
//   dmem_rdata, dmem_ack        memory response
//   stall               hold IF..EX/MEM this cycle
//   bus_err             one-cycle pulse when an access times out
//   misalign_trap       (macro only) misaligned access refused
//   wb_out, wb_valid    MEM/WB bundle and its valid flag
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int WIDTH   = 107,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [0:31]      next_pc,
   input  logic [0:4]       dest_reg,
   input  logic [0:31]      alu_result,
   input  logic [0:31]      store_data,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             pc_to_reg,
   input  logic             reg_write,
   input  logic             mem_to_reg,
   input  logic             load_sign,
   input  logic [0:1]       dsize,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [0:31]      dmem_addr,
   output logic [0:31]      dmem_wdata,
   output logic [0:3]       dmem_be,
   input  logic [0:31]      dmem_rdata,
   input  logic             dmem_ack,
   output logic             stall,
   output logic             bus_err,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   output logic             misalign_trap,
`endif
   output logic [0:WIDTH-1] wb_out,
   output logic             wb_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Counter value seen in the last permitted WAIT cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   // ---------------------------------------------------------------------
   // Formatting helpers
   // ---------------------------------------------------------------------

   // Select the addressed lane(s) and extend to a full word.
   function automatic logic [0:31] loadFormat(input logic [0:31] rd,
                                              input logic [0:1]  off,
                                              input logic [0:1]  size,
                                              input logic        sgn);
      logic [0:7]  b;
      logic [0:15] h;
      logic [0:31] r;
      b = 8'h00;
      h = 16'h0000;
      r = 32'h0000_0000;
      case (off)
         2'd0:    b = rd[0:7];
         2'd1:    b = rd[8:15];
         2'd2:    b = rd[16:23];
         default: b = rd[24:31];
      endcase
      // off[0] is the MSB of the offset: halfword 0 or halfword 2.
      if (off[0]) begin
         h = rd[16:31];
      end else begin
         h = rd[0:15];
      end
      case (size)
         2'b00:   r = {{24{sgn & b[0]}}, b};
         2'b01:   r = {{16{sgn & h[0]}}, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   // Byte enables for the addressed lane(s); be[0] covers bits [0:7].
   function automatic logic [0:3] laneEnables(input logic [0:1] off,
                                              input logic [0:1] size);
      logic [0:3] be;
      be = 4'b0000;
      case (size)
         2'b00: begin
            case (off)
               2'd0:    be = 4'b1000;
               2'd1:    be = 4'b0100;
               2'd2:    be = 4'b0010;
               default: be = 4'b0001;
            endcase
         end
         2'b01:   be = off[0] ? 4'b0011 : 4'b1100;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate the low-order store bytes across every lane they could hit.
   function automatic logic [0:31] storeWord(input logic [0:31] sd,
                                             input logic [0:1]  size);
      logic [0:31] w;
      w = 32'h0000_0000;
      case (size)
         2'b00:   w = {4{sd[24:31]}};
         2'b01:   w = {2{sd[16:31]}};
         default: w = sd;
      endcase
      return w;
   endfunction

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   // Half needs an even offset; word needs offset 0.
   function automatic logic isMisaligned(input logic [0:1] off,
                                         input logic [0:1] size);
      logic m;
      m = 1'b0;
      case (size)
         2'b00:   m = 1'b0;
         2'b01:   m = off[1];
         default: m = (off != 2'b00);
      endcase
      return m;
   endfunction
`endif

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   state_t      state_r;
   state_t      stateNext_s;

   logic        dmemReq_r;
   logic        dmemWe_r;
   logic [0:31] dmemAddr_r;
   logic [0:31] dmemWdata_r;
   logic [0:3]  dmemBe_r;
   logic        busErr_r;
   logic [7:0]  cnt_r;

   logic [0:31] opNextPc_r;
   logic [0:4]  opDest_r;
   logic [0:31] opAlu_r;
   logic        opPcToReg_r;
   logic        opRegWrite_r;
   logic        opMemToReg_r;
   logic        opLoadSign_r;
   logic [0:1]  opDsize_r;
   logic        opIsLoad_r;
   logic [0:31] rdata_r;

   logic        memOp_s;
   logic        accept_s;
   logic        ackTake_s;
   logic        timeout_s;
   logic        stall_s;
   logic        wbValid_s;
   logic [0:WIDTH-1] wbOut_s;
   logic [0:31] respData_s;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic        trap_s;
`endif

   assign memOp_s = mem_read | mem_write;

   // Next-state and combinational outputs; everything defaults to a bubble.
   always_comb begin
      stateNext_s = state_r;
      stall_s     = 1'b0;
      wbValid_s   = 1'b0;
      wbOut_s     = {WIDTH{1'b0}};
      accept_s    = 1'b0;
      ackTake_s   = 1'b0;
      timeout_s   = 1'b0;
      respData_s  = 32'h0000_0000;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      trap_s      = 1'b0;
`endif
      if (reset) begin
         stateNext_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (busErr_r) begin
                  // The timed-out instruction is still on the inputs; let it
                  // leave EX/MEM as a bubble instead of re-issuing it.
                  stateNext_s = ST_IDLE;
               end else if (in_valid && !memOp_s) begin
                  wbOut_s     = {next_pc, dest_reg, alu_result, 32'h0000_0000,
                                 pc_to_reg, reg_write, mem_to_reg, load_sign,
                                 dsize};
                  wbValid_s   = 1'b1;
                  stateNext_s = ST_IDLE;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
               end else if (in_valid && isMisaligned(alu_result[30:31], dsize)) begin
                  trap_s      = 1'b1;
                  stateNext_s = ST_IDLE;
`endif
               end else if (in_valid) begin
                  accept_s    = 1'b1;
                  stall_s     = 1'b1;
                  stateNext_s = ST_WAIT;
               end else begin
                  stateNext_s = ST_IDLE;
               end
            end
            ST_WAIT: begin
               stall_s = 1'b1;
               if (dmem_ack) begin
                  ackTake_s   = 1'b1;
                  stateNext_s = ST_RESP;
               end else if (cnt_r == TIMEOUT_LAST) begin
                  timeout_s   = 1'b1;
                  stateNext_s = ST_IDLE;
               end else begin
                  stateNext_s = ST_WAIT;
               end
            end
            ST_RESP: begin
               if (opIsLoad_r) begin
                  respData_s = loadFormat(rdata_r, opAlu_r[30:31], opDsize_r,
                                          opLoadSign_r);
               end else begin
                  respData_s = 32'h0000_0000;
               end
               wbOut_s     = {opNextPc_r, opDest_r, opAlu_r, respData_s,
                              opPcToReg_r, opRegWrite_r, opMemToReg_r,
                              opLoadSign_r, opDsize_r};
               wbValid_s   = 1'b1;
               stateNext_s = ST_IDLE;
            end
            default: begin
               stateNext_s = ST_IDLE;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= stateNext_s;
      end
   end

   // Memory request, timeout counter and latched instruction fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         dmemReq_r    <= 1'b0;
         dmemWe_r     <= 1'b0;
         dmemAddr_r   <= 32'h0000_0000;
         dmemWdata_r  <= 32'h0000_0000;
         dmemBe_r     <= 4'b0000;
         busErr_r     <= 1'b0;
         cnt_r        <= 8'd0;
         opNextPc_r   <= 32'h0000_0000;
         opDest_r     <= 5'd0;
         opAlu_r      <= 32'h0000_0000;
         opPcToReg_r  <= 1'b0;
         opRegWrite_r <= 1'b0;
         opMemToReg_r <= 1'b0;
         opLoadSign_r <= 1'b0;
         opDsize_r    <= 2'b00;
         opIsLoad_r   <= 1'b0;
         rdata_r      <= 32'h0000_0000;
      end else begin
         busErr_r <= timeout_s;
         if (accept_s) begin
            dmemReq_r    <= 1'b1;
            dmemWe_r     <= mem_write;
            dmemAddr_r   <= {alu_result[0:29], 2'b00};
            dmemBe_r     <= laneEnables(alu_result[30:31], dsize);
            dmemWdata_r  <= mem_write ? storeWord(store_data, dsize) : 32'h0000_0000;
            cnt_r        <= 8'd0;
            opNextPc_r   <= next_pc;
            opDest_r     <= dest_reg;
            opAlu_r      <= alu_result;
            opPcToReg_r  <= pc_to_reg;
            opRegWrite_r <= reg_write;
            opMemToReg_r <= mem_to_reg;
            opLoadSign_r <= load_sign;
            opDsize_r    <= dsize;
            opIsLoad_r   <= mem_read & ~mem_write;
         end else if (ackTake_s) begin
            dmemReq_r <= 1'b0;
            dmemWe_r  <= 1'b0;
            rdata_r   <= dmem_rdata;
         end else if (timeout_s) begin
            dmemReq_r <= 1'b0;
            dmemWe_r  <= 1'b0;
            cnt_r     <= 8'd0;
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 8'd1;
         end
      end
   end

   assign dmem_req   = dmemReq_r;
   assign dmem_we    = dmemWe_r;
   assign dmem_addr  = dmemAddr_r;
   assign dmem_wdata = dmemWdata_r;
   assign dmem_be    = dmemBe_r;
   assign bus_err    = busErr_r;
   assign stall      = stall_s;
   assign wb_out     = wbOut_s;
   assign wb_valid   = wbValid_s;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign misalign_trap = trap_s;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: each instruction is expanded by a transaction-level
// model into the per-cycle outputs it must produce; a compare process checks
// every cycle against that expectation.
module tb_mem_stage;
   localparam int WIDTH   = 107;
   localparam int TIMEOUT = 4;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] next_pc = 32'h0, alu_result = 32'h0, store_data = 32'h0;
   logic [4:0]  dest_reg = 5'd0;
   logic        mem_read = 1'b0, mem_write = 1'b0, pc_to_reg = 1'b0;
   logic        reg_write = 1'b0, mem_to_reg = 1'b0, load_sign = 1'b0;
   logic [1:0]  dsize = 2'b00;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0, stall, bus_err, wb_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'h0;
   logic [3:0]  dmem_be;
   logic [WIDTH-1:0] wb_out;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic        misalign_trap;
`endif

   mem_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .next_pc(next_pc),
      .dest_reg(dest_reg), .alu_result(alu_result), .store_data(store_data),
      .mem_read(mem_read), .mem_write(mem_write), .pc_to_reg(pc_to_reg),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .load_sign(load_sign),
      .dsize(dsize), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
      .bus_err(bus_err),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      .misalign_trap(misalign_trap),
`endif
      .wb_out(wb_out), .wb_valid(wb_valid));

   typedef struct {
      logic        valid;
      logic [31:0] pc, alu, sd;
      logic [4:0]  rd;
      logic        mr, mw, p2r, rw, m2r, ls;
      logic [1:0]  sz;
   } instr_t;

   typedef struct {
      logic         stall, valid, req, busErr, trap;
      logic [106:0] wb;
      logic         chkBus, we, chkWdata, litEn;
      logic [31:0]  addr, wdata, litData;
      logic [3:0]   be;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycleNo = 0;

   task automatic chk(input string nm, input logic [106:0] act, input logic [106:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cycleNo, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [3:0] mBe(input logic [31:0] a, input logic [1:0] sz);
      case (sz)
         2'b00:   return 4'(4'b1000 >> a[1:0]);
         2'b01:   return a[1] ? 4'b0011 : 4'b1100;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] mWdata(input logic [31:0] d, input logic [1:0] sz);
      case (sz)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] mLoad(input logic [31:0] w, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * (3 - a[1:0])));
      h = a[1] ? w[15:0] : w[31:16];
      case (sz)
         2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
         2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic mIsMis(input instr_t i);
      if (i.sz == 2'b00) return 1'b0;
      if (i.sz == 2'b01) return i.alu[0];
      return i.alu[1:0] != 2'b00;
   endfunction

   function automatic logic [106:0] mBundle(input instr_t i, input logic [31:0] data);
      return {i.pc, i.rd, i.alu, data, i.p2r, i.rw, i.m2r, i.ls, i.sz};
   endfunction

   function automatic exp_t blankExp();
      exp_t e;
      e.stall = 1'b0; e.valid = 1'b0; e.req = 1'b0; e.busErr = 1'b0; e.trap = 1'b0;
      e.wb = 107'h0; e.chkBus = 1'b0; e.we = 1'b0; e.chkWdata = 1'b0; e.litEn = 1'b0;
      e.addr = 32'h0; e.wdata = 32'h0; e.litData = 32'h0; e.be = 4'h0;
      return e;
   endfunction

   function automatic instr_t randInstr(input int kind);
      instr_t i;
      int r;
      i.valid = (kind != 0);
      i.pc = $urandom; i.alu = $urandom; i.sd = $urandom; i.rd = 5'($urandom);
      i.p2r = 1'($urandom); i.rw = 1'($urandom); i.m2r = 1'($urandom);
      i.ls = 1'($urandom); i.sz = 2'($urandom);
      r = $urandom_range(0, 3);
      if (kind == 1) begin
         i.mr = 1'b0; i.mw = 1'b0;
      end else begin
         i.mr = (r != 1); i.mw = (r == 1 || r == 2);
      end
      return i;
   endfunction

   // Drive one cycle of inputs and queue that cycle's expectation.
   task automatic cyc(input instr_t i, input logic rst, input logic ack,
                      input logic [31:0] rd, input exp_t e);
      @(posedge clk); #1;
      reset = rst; in_valid = i.valid; next_pc = i.pc; dest_reg = i.rd;
      alu_result = i.alu; store_data = i.sd; mem_read = i.mr; mem_write = i.mw;
      pc_to_reg = i.p2r; reg_write = i.rw; mem_to_reg = i.m2r; load_sign = i.ls;
      dsize = i.sz; dmem_ack = ack; dmem_rdata = rd;
      expQ.push_back(e);
   endtask

   // Expand one instruction into its cycles. ackAt: WAIT cycle carrying the
   // ack (0 = never). rstAt: WAIT cycle in which reset is raised (0 = none).
   task automatic runInstr(input instr_t i, input int ackAt, input int rstAt,
                           input logic [31:0] rdv, input logic litEn,
                           input logic [31:0] litData);
      exp_t   e;
      instr_t idle;
      logic   isLoad;
      e = blankExp();
      if (!i.valid) begin
         cyc(i, 1'b0, 1'($urandom), $urandom, e);
         return;
      end
      if (!i.mr && !i.mw) begin
         e.valid = 1'b1; e.wb = mBundle(i, 32'h0); e.litEn = litEn; e.litData = litData;
         cyc(i, 1'b0, 1'($urandom), $urandom, e);
         return;
      end
      if (TRAP_EN && mIsMis(i)) begin
         e.trap = 1'b1;
         cyc(i, 1'b0, 1'($urandom), $urandom, e);
         return;
      end
      isLoad = i.mr && !i.mw;
      e.stall = 1'b1;                                   // accept cycle
      cyc(i, 1'b0, 1'($urandom), $urandom, e);
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (k == rstAt) begin
            e = blankExp(); e.req = 1'b1;               // request still registered
            cyc(i, 1'b1, 1'b0, $urandom, e);
            idle = randInstr(0);
            e = blankExp(); e.chkBus = 1'b1; e.chkWdata = 1'b1;
            cyc(idle, 1'b0, 1'b1, $urandom, e);          // late ack ignored
            return;
         end
         e = blankExp();
         e.stall = 1'b1; e.req = 1'b1; e.chkBus = 1'b1; e.we = i.mw;
         e.addr = {i.alu[31:2], 2'b00}; e.be = mBe(i.alu, i.sz);
         e.chkWdata = i.mw; e.wdata = mWdata(i.sd, i.sz);
         if (k == ackAt) begin
            cyc(i, 1'b0, 1'b1, rdv, e);
            e = blankExp();
            e.valid = 1'b1;
            e.wb = mBundle(i, isLoad ? mLoad(rdv, i.alu, i.sz, i.ls) : 32'h0);
            e.litEn = litEn; e.litData = litData;
            cyc(i, 1'b0, 1'($urandom), $urandom, e);
            return;
         end
         cyc(i, 1'b0, 1'b0, $urandom, e);
      end
      e = blankExp(); e.busErr = 1'b1;                   // timed out: drop cycle
      cyc(i, 1'b0, 1'($urandom), $urandom, e);
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      exp_t e;
      cycleNo++;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         chk("stall", 107'(stall), 107'(e.stall));
         chk("wb_valid", 107'(wb_valid), 107'(e.valid));
         chk("wb_out", wb_out, e.wb);
         chk("dmem_req", 107'(dmem_req), 107'(e.req));
         chk("bus_err", 107'(bus_err), 107'(e.busErr));
         if (e.chkBus) begin
            chk("dmem_we", 107'(dmem_we), 107'(e.we));
            chk("dmem_addr", 107'(dmem_addr), 107'(e.addr));
            chk("dmem_be", 107'(dmem_be), 107'(e.be));
         end
         if (e.chkWdata) chk("dmem_wdata", 107'(dmem_wdata), 107'(e.wdata));
         if (e.litEn) chk("data_literal", 107'(wb_out[37:6]), 107'(e.litData));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         chk("misalign_trap", 107'(misalign_trap), 107'(e.trap));
`endif
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t i;
      exp_t   e;
      int     r, ackAt, rstAt;

      // Pin the model to hand-computed values.
      chk("pin_be_byte3", 107'(mBe(32'h0000_1003, 2'b00)), 107'(4'b0001));
      chk("pin_be_half2", 107'(mBe(32'h0000_0202, 2'b01)), 107'(4'b0011));
      chk("pin_wdata_half", 107'(mWdata(32'hDEAD_BEEF, 2'b01)), 107'(32'hBEEF_BEEF));
      chk("pin_load_sbyte", 107'(mLoad(32'h1122_33F0, 32'h1003, 2'b00, 1'b1)), 107'(32'hFFFF_FFF0));
      chk("pin_load_ubyte", 107'(mLoad(32'h1122_33F0, 32'h1003, 2'b00, 1'b0)), 107'(32'h0000_00F0));
      chk("pin_load_shalf", 107'(mLoad(32'h8001_7FFF, 32'h0, 2'b01, 1'b1)), 107'(32'hFFFF_8001));

      // Reset state, checked while reset is still high.
      i = randInstr(2);
      e = blankExp(); e.chkBus = 1'b1; e.chkWdata = 1'b1;
      cyc(i, 1'b1, 1'b1, $urandom, e);
      cyc(i, 1'b1, 1'b0, $urandom, e);

      // ALU op pass-through.
      i = randInstr(1);
      i.pc = 32'h0000_0104; i.rd = 5'd5; i.rw = 1'b1; i.alu = 32'h0000_0ABC;
      i.p2r = 1'b0; i.m2r = 1'b0; i.ls = 1'b0; i.sz = 2'b00;
      chk("pin_alu_bundle", mBundle(i, 32'h0),
          {32'h0000_0104, 5'd5, 32'h0000_0ABC, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
      runInstr(i, 0, 0, 32'h0, 1'b1, 32'h0);

      // Signed and unsigned byte load at lane 3, ack in the second WAIT cycle.
      i = randInstr(2); i.mr = 1'b1; i.mw = 1'b0; i.sz = 2'b00;
      i.alu = 32'h0000_1003; i.ls = 1'b1;
      runInstr(i, 2, 0, 32'h1122_33F0, 1'b1, 32'hFFFF_FFF0);
      i.ls = 1'b0;
      runInstr(i, 2, 0, 32'h1122_33F0, 1'b1, 32'h0000_00F0);

      // Half store at offset 2.
      i = randInstr(2); i.mr = 1'b0; i.mw = 1'b1; i.sz = 2'b01;
      i.alu = 32'h0000_0202; i.sd = 32'hDEAD_BEEF;
      runInstr(i, 1, 0, $urandom, 1'b1, 32'h0);

      // Timeout, then ack exactly in the last permitted WAIT cycle.
      i = randInstr(2); i.mr = 1'b1; i.mw = 1'b0; i.sz = 2'b10; i.alu = 32'h0000_0400;
      runInstr(i, 0, 0, $urandom, 1'b0, 32'h0);
      runInstr(i, TIMEOUT, 0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);

      // Reset in the second WAIT cycle, late ack, then IDLE behaviour.
      runInstr(i, 0, 2, $urandom, 1'b0, 32'h0);
      runInstr(randInstr(1), 0, 0, 32'h0, 1'b0, 32'h0);

      // Read and write both set behaves as a store.
      i = randInstr(2); i.mr = 1'b1; i.mw = 1'b1; i.sz = 2'b00; i.alu = 32'h0000_0011;
      runInstr(i, 1, 0, $urandom, 1'b1, 32'h0);

      // Misaligned word load.
      i = randInstr(2); i.mr = 1'b1; i.mw = 1'b0; i.sz = 2'b10; i.alu = 32'h0000_0006;
      runInstr(i, 1, 0, 32'h0102_0304, 1'b0, 32'h0);

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         ackAt = $urandom_range(0, TIMEOUT);
         rstAt = ($urandom_range(0, 19) == 0) ? $urandom_range(1, TIMEOUT) : 0;
         if (rstAt != 0) ackAt = 0;
         if (r < 2)      i = randInstr(0);
         else if (r < 5) i = randInstr(1);
         else            i = randInstr(2);
         runInstr(i, ackAt, rstAt, $urandom, 1'b0, 32'h0);
      end

      @(negedge clk); #1;
      chk("queue_drain", 107'(expQ.size()), 107'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
